clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider; successor to the fixed-N divider.
- Divisor comes from a port, not a parameter, and is any integer 2..2^WIDTH-1. Duty cycle is 50% for both even and odd divisors.
- Adds:
  - glitch-free divisor change at period boundary
  - clean enable/disable
  - divisor status outputs
- Sits in the clock/reset unit, feeding slow peripheral clock domains from the main clock.

Parameters:
- WIDTH, 8, bit width of divisor and period counter.
- DEFAULT_DIV, 7, divisor loaded at reset; legal range 2..2^WIDTH-1, elaboration error otherwise.

Ports:
- clk  in  1  source clock; both edges used.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run request; 0 parks output low at a period boundary.
- div_val  in  WIDTH  requested divisor.
- div_load  in  1  one-cycle strobe; captures div_val into the pending register.
- div_busy  out  1  a pending divisor is not yet applied.
- div_err  out  1  one-cycle pulse; div_load carried div_val < 2, request dropped.
- cur_div  out  WIDTH  divisor currently in effect.
- active  out  1  divider running (not parked).
- clk_out  out  1  divided clock.

Behaviour:
- Reset, sampled at posedge for posedge flops:
  - cnt=0, pos_hi=0, cur_div=DEFAULT_DIV, pend=0, div_busy=0, div_err=0, active=0.
- Reset, sampled at negedge: neg_hi=0.
- clk_out=0 while reset is held.
- Counter: D=cur_div, H=D>>1. When active, cnt counts 0..D-1 at posedge and wraps to 0.
- pos_hi register, updated at posedge:
  - takes (cnt_next >= H) for even D;
  - takes (cnt_next > H) for odd D.
- Equivalent to comparing the registered cnt, but glitch-free.
- neg_hi: at negedge, neg_hi <= pos_hi when D is odd, else 0.
- clk_out = pos_hi | neg_hi. Only these two flops feed the output OR; no other combinational path to clk_out.
- Resulting waveform:
  - even D: low D/2, high D/2 source cycles;
  - odd D: low (D-1)/2+0.5, high (D-1)/2+0.5 cycles.
- Period boundary: the posedge at which cnt==D-1, i.e. cnt wraps to 0.
- Divisor update:
  - div_load with div_val>=2: pend<=div_val, div_busy=1 next cycle.
  - A repeated div_load while busy overwrites pend; the last request wins.
  - At the next period boundary: cur_div<=pend, div_busy<=0. The new period starts with cnt=0 under the new D. No partial period and no runt pulse.
  - If parked (active=0), pend applies on the next cycle.
  - div_load with div_val 0 or 1: div_err pulses 1 cycle the next cycle; pend and cur_div unchanged.
  - If div_load and boundary coincide, the currently pending value applies and the new request becomes pending (busy stays 1).
- Enable:
  - While parked: cnt=0, pos_hi=0, clk_out=0.
  - en=1 while parked: active=1 next posedge, cnt starts 0.
  - en=0 while running: the current period completes; at its boundary active<=0, cnt holds 0, clk_out stays low. No truncated high phase.
- Reset mid-operation: immediate return to reset state. Pending divisor discarded; clk_out low from the posedge/negedge that samples reset.
- D change between odd and even takes effect only at a boundary, where pos_hi=neg_hi=0, so the duty mode switch is glitch-free.

Optional Feature:
- Macro CLK_DIV_SYNC_PULSE_EN.
- Defined:
  - Adds output rise_stb (1 bit, reset 0). It is a one-clk-cycle pulse, clk-domain, asserted on the posedge where pos_hi goes 0->1.
  - Lets clk-domain logic align with clk_out rising edges without sampling clk_out.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, en=1, DEFAULT_DIV=7 -> clk_out period 7 clk cycles, high 3.5 cycles; cur_div=7; div_busy=0.
- div_load with div_val=4 mid-period -> div_busy=1 until the boundary. Remaining period stays 7-cycle. Following periods are 4 cycles, 2 high/2 low; no runt pulse.
- div_load=5, then div_load=10 two cycles later, same period -> only 10 applied at boundary; cur_div=10; period 10, 5 high.
- div_load with div_val=1, then div_val=0 -> div_err pulses each time; cur_div, div_busy unchanged.
- en=0 at cnt=2 with D=6 -> high phase (cnt 3..5) completes; active=0 after boundary; clk_out held 0. en=1 -> a new period starts at cnt=0.
- reset asserted mid-high phase with D=9 and a pending load -> clk_out=0, cur_div=7, div_busy=0 after reset. With CLK_DIV_SYNC_PULSE_EN, rise_stb pulses once per period only after reset release.

Source files
------------

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50% duty clock divider with glitch-free divisor change.
// Optional CLK_DIV_SYNC_PULSE_EN adds rise_stb, a clk-domain pulse per rising edge.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_busy,
  output logic             div_err,
  output logic [WIDTH-1:0] cur_div,
  output logic             active,
  output logic             clk_out
`ifdef CLK_DIV_SYNC_PULSE_EN
  ,
  output logic             rise_stb
`endif
);

  if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2**WIDTH) - 1) begin : g_bad_div
    $error("clk_div_prog: DEFAULT_DIV out of range 2..2^WIDTH-1");
  end

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] last;
  logic             pos_hi;
  logic             neg_hi;
  logic             hi_nxt;
  logic             boundary;
  logic             load_ok;
  logic             load_bad;
  logic             apply;

  assign half     = cur_div >> 1;
  assign last     = cur_div - WIDTH'(1);
  assign boundary = active && (cnt == last);
  assign load_ok  = div_load && (div_val >= WIDTH'(2));
  assign load_bad = div_load && (div_val <  WIDTH'(2));
  assign apply    = div_busy && (boundary || !active);

  // next count and next high-phase flag, both zero while parked or wrapping
  always_comb begin
    cnt_nxt = '0;
    hi_nxt  = 1'b0;
    if (active && !boundary) begin
      cnt_nxt = cnt + WIDTH'(1);
    end
    if (active) begin
      if (cur_div[0]) begin
        hi_nxt = (cnt_nxt > half);
      end else begin
        hi_nxt = (cnt_nxt >= half);
      end
    end
  end

  // period counter, run state and divisor bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      pos_hi   <= 1'b0;
      cur_div  <= WIDTH'(DEFAULT_DIV);
      pend     <= '0;
      div_busy <= 1'b0;
      div_err  <= 1'b0;
      active   <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      pos_hi  <= hi_nxt;
      div_err <= load_bad;
      if (!active || boundary) begin
        active <= en;
      end
      if (apply) begin
        cur_div <= pend;
      end
      if (load_ok) begin
        pend     <= div_val;
        div_busy <= 1'b1;
      end else if (apply) begin
        div_busy <= 1'b0;
      end
    end
  end

  // half-cycle extension of the high phase for odd divisors
  always_ff @(negedge clk) begin
    if (reset) begin
      neg_hi <= 1'b0;
    end else begin
      neg_hi <= cur_div[0] & pos_hi;
    end
  end

  assign clk_out = pos_hi | neg_hi;

`ifdef CLK_DIV_SYNC_PULSE_EN
  // one-cycle strobe on the edge where the high phase starts
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_stb <= 1'b0;
    end else begin
      rise_stb <= hi_nxt & ~pos_hi;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog.
// Waveform lengths are measured in half source cycles.
`timescale 1ns/1ps
module tb_clk_div_prog;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [W-1:0] div_val;
  logic         div_load;
  logic         div_busy;
  logic         div_err;
  logic [W-1:0] cur_div;
  logic         active;
  logic         clk_out;
`ifdef CLK_DIV_SYNC_PULSE_EN
  logic         rise_stb;
`endif

  int checks   = 0;
  int failures = 0;
  int per;
  int hi;
  int n;

  always #5 clk = ~clk;

  clk_div_prog #(
    .WIDTH      (W),
    .DEFAULT_DIV(7)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .div_val (div_val),
    .div_load(div_load),
    .div_busy(div_busy),
    .div_err (div_err),
    .cur_div (cur_div),
    .active  (active),
    .clk_out (clk_out)
`ifdef CLK_DIV_SYNC_PULSE_EN
    ,
    .rise_stb(rise_stb)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half_step();
    @(posedge clk or negedge clk);
    #1;
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 300; i++) begin
      if (!div_busy) break;
      tick();
    end
    chk("busy_cleared", 32'(div_busy), 0);
  endtask

  task automatic wait_rise();
    logic prev;
    bit   got;
    got  = 0;
    prev = clk_out;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!prev && clk_out) begin
        got = 1;
        break;
      end
      prev = clk_out;
    end
    chk("rise_found", 32'(got), 1);
  endtask

  task automatic meas(output int per_h, output int hi_h);
    logic prev;
    logic cur;
    bit   got;
    per_h = 0;
    hi_h  = 0;
    got   = 0;
    prev  = clk_out;
    for (int i = 0; i < 1000; i++) begin
      half_step();
      cur = clk_out;
      if (!prev && cur) begin
        got = 1;
        break;
      end
      prev = cur;
    end
    if (got) begin
      got   = 0;
      per_h = 1;
      hi_h  = 1;
      prev  = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        half_step();
        cur = clk_out;
        if (!prev && cur) begin
          got = 1;
          break;
        end
        per_h++;
        if (cur) hi_h++;
        prev = cur;
      end
      if (!got) begin
        per_h = 0;
        hi_h  = 0;
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    div_load = 1'b0;
    div_val  = '0;
    repeat (3) tick();
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_cur_div", 32'(cur_div), 7);
    chk("rst_busy", 32'(div_busy), 0);
    chk("rst_err", 32'(div_err), 0);
    chk("rst_active", 32'(active), 0);

    reset = 1'b0;
    en    = 1'b1;
    tick();
    chk("run_active", 32'(active), 1);
    meas(per, hi);
    chk("d7_period", 32'(per), 14);
    chk("d7_high", 32'(hi), 7);

    tick();
    div_val  = 8'd4;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    chk("ld4_busy", 32'(div_busy), 1);
    chk("ld4_cur_old", 32'(cur_div), 7);
    tick();
    chk("ld4_busy_clr", 32'(div_busy), 0);
    chk("ld4_cur_new", 32'(cur_div), 4);
    meas(per, hi);
    chk("d4_period", 32'(per), 8);
    chk("d4_high", 32'(hi), 4);

    repeat (2) tick();
    div_val  = 8'd5;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    tick();
    div_val  = 8'd10;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    chk("ld10_busy", 32'(div_busy), 1);
    chk("ld10_cur_old", 32'(cur_div), 4);
    tick();
    chk("ld10_cur_new", 32'(cur_div), 10);
    chk("ld10_busy_clr", 32'(div_busy), 0);
    meas(per, hi);
    chk("d10_period", 32'(per), 20);
    chk("d10_high", 32'(hi), 10);

    div_val  = 8'd1;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    chk("err1_pulse", 32'(div_err), 1);
    chk("err1_busy", 32'(div_busy), 0);
    chk("err1_cur", 32'(cur_div), 10);
    tick();
    chk("err1_clr", 32'(div_err), 0);
    div_val  = 8'd0;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    chk("err0_pulse", 32'(div_err), 1);
    chk("err0_busy", 32'(div_busy), 0);
    chk("err0_cur", 32'(cur_div), 10);

    div_val  = 8'd6;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    wait_busy();
    chk("d6_cur", 32'(cur_div), 6);
    wait_rise();
    repeat (5) tick();
    en = 1'b0;
    n  = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (clk_out) n++;
    end
    chk("dis_high_cnt", 32'(n), 3);
    chk("dis_active", 32'(active), 0);
    chk("dis_clk_out", 32'(clk_out), 0);
    en = 1'b1;
    tick();
    chk("reen_active", 32'(active), 1);
    meas(per, hi);
    chk("d6_period", 32'(per), 12);
    chk("d6_high", 32'(hi), 6);

    div_val  = 8'd9;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    wait_busy();
    chk("d9_cur", 32'(cur_div), 9);
    wait_rise();
    tick();
    div_val  = 8'd3;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    chk("pre_rst_busy", 32'(div_busy), 1);
    chk("pre_rst_clk_out", 32'(clk_out), 1);
    reset = 1'b1;
    tick();
    @(negedge clk);
    #1;
    chk("mid_rst_clk_out", 32'(clk_out), 0);
    chk("mid_rst_cur", 32'(cur_div), 7);
    chk("mid_rst_busy", 32'(div_busy), 0);
    chk("mid_rst_active", 32'(active), 0);
`ifdef CLK_DIV_SYNC_PULSE_EN
    chk("mid_rst_stb", 32'(rise_stb), 0);
`endif
    reset = 1'b0;
    tick();
    chk("post_rst_active", 32'(active), 1);
`ifdef CLK_DIV_SYNC_PULSE_EN
    n = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (rise_stb) n++;
    end
    chk("stb_count", 32'(n), 2);
`endif
    meas(per, hi);
    chk("post_rst_period", 32'(per), 14);
    chk("post_rst_high", 32'(hi), 7);
    chk("post_rst_cur", 32'(cur_div), 7);
    chk("post_rst_busy", 32'(div_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
